// File: rtl/bt_sim_pkg.sv
// Shared definitions for the simulated air channel: receiver lock states and
// the error-injection LFSR polynomial.
package bt_sim_pkg;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_SETTLING = 2'd1,
        RX_LOCKED   = 2'd2
    } rx_state_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bt_air_rx_lock.sv
// Per-receiver PLL settle model: a receiver only listens once it has been
// enabled (or retuned) for SETTLE_CYC consecutive cycles.
module bt_air_rx_lock
    import bt_sim_pkg::*;
#(
    parameter int FKW        = 7,
    parameter int SETTLE_CYC = 900
) (
    input  logic           clk_6M,
    input  logic           rstz,
    input  logic           rxen,
    input  logic [FKW-1:0] rxfk,
    output logic           rxlocked
);

    localparam logic [9:0] LAST_CNT = 10'(SETTLE_CYC - 1);

    rx_state_t      state, state_nxt;
    logic [9:0]     cnt, cnt_nxt;
    logic [FKW-1:0] fk_q;

    // State, settle counter and previous tuning word
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state <= RX_IDLE;
            cnt   <= '0;
            fk_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fk_q  <= rxfk;
        end
    end

    // Next state: disable wins over retune; a retune only restarts a locked PLL
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!rxen) begin
            state_nxt = RX_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    state_nxt = RX_SETTLING;
                    cnt_nxt   = '0;
                end
                RX_SETTLING: begin
                    if (cnt == LAST_CNT) state_nxt = RX_LOCKED;
                    else                 cnt_nxt   = cnt + 10'd1;
                end
                RX_LOCKED: begin
                    if (rxfk != fk_q) begin
                        state_nxt = RX_SETTLING;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = RX_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign rxlocked = (state == RX_LOCKED);

endmodule

// File: rtl/bt_air_channel.sv
// Shared RF channel: delays every transmitter by DELAY cycles, routes each
// air symbol to locked receivers on the same hop frequency, flags collisions
// and optionally flips the symbol LSB from an LFSR-driven error source.
module bt_air_channel
    import bt_sim_pkg::*;
#(
    parameter int NUM_DEV    = 2,
    parameter int DELAY      = 2,
    parameter int SETTLE_CYC = 900,
    parameter int FKW        = 7
) (
    input  logic                   clk_6M,
    input  logic                   rstz,
    input  logic [NUM_DEV-1:0]     txen,
    input  logic [3*NUM_DEV-1:0]   txsymbol,
    input  logic [FKW*NUM_DEV-1:0] txfk,
    input  logic [NUM_DEV-1:0]     rxen,
    input  logic [FKW*NUM_DEV-1:0] rxfk,
    input  logic                   regi_err_en,
    input  logic [7:0]             regi_ber_thresh,
    input  logic [15:0]            regi_lfsr_seed,
    output logic [3*NUM_DEV-1:0]   rxsymbol,
    output logic [NUM_DEV-1:0]     rxlocked,
    output logic [NUM_DEV-1:0]     collision,
    output logic [15:0]            collision_cnt
);

    logic [NUM_DEV-1:0]     en_pipe  [DELAY];
    logic [3*NUM_DEV-1:0]   sym_pipe [DELAY];
    logic [FKW*NUM_DEV-1:0] fk_pipe  [DELAY];

    logic [15:0]            lfsr, seed_eff;
    logic                   err_en_q, corrupt;
    logic [3*NUM_DEV-1:0]   sym_d;
    logic [NUM_DEV-1:0]     col_d;
    logic [3:0]             ncol;
    logic [16:0]            cnt_sum;

    assign seed_eff = (regi_lfsr_seed == 16'h0000) ? LFSR_DEFAULT_SEED : regi_lfsr_seed;
    assign corrupt  = regi_err_en && (lfsr[7:0] < regi_ber_thresh);

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_rx
        bt_air_rx_lock #(
            .FKW        (FKW),
            .SETTLE_CYC (SETTLE_CYC)
        ) u_lock (
            .clk_6M   (clk_6M),
            .rstz     (rstz),
            .rxen     (rxen[g]),
            .rxfk     (rxfk[g*FKW +: FKW]),
            .rxlocked (rxlocked[g])
        );
    end

    // Air latency shift pipeline for enable, symbol and frequency
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int unsigned s = 0; s < DELAY; s++) begin
                en_pipe[s]  <= '0;
                sym_pipe[s] <= '0;
                fk_pipe[s]  <= '0;
            end
        end else begin
            en_pipe[0]  <= txen;
            sym_pipe[0] <= txsymbol;
            fk_pipe[0]  <= txfk;
            for (int unsigned s = 1; s < DELAY; s++) begin
                en_pipe[s]  <= en_pipe[s-1];
                sym_pipe[s] <= sym_pipe[s-1];
                fk_pipe[s]  <= fk_pipe[s-1];
            end
        end
    end

    // Error LFSR: free-running, reseeded on an enable rising edge
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            lfsr     <= seed_eff;
            err_en_q <= 1'b0;
        end else begin
            err_en_q <= regi_err_en;
            lfsr     <= (regi_err_en && !err_en_q) ? seed_eff : lfsr_next(lfsr);
        end
    end

    // Routing decode: count co-channel transmitters seen by each receiver
    always_comb begin
        logic [3:0] hits;
        logic [2:0] pick;
        sym_d = '0;
        col_d = '0;
        hits  = '0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            hits = '0;
            pick = '0;
            for (int unsigned j = 0; j < NUM_DEV; j++) begin
                if (j != i && en_pipe[DELAY-1][j] &&
                    fk_pipe[DELAY-1][j*FKW +: FKW] == rxfk[i*FKW +: FKW]) begin
                    hits = hits + 4'd1;
                    pick = sym_pipe[DELAY-1][j*3 +: 3];
                end
            end
            if (rxlocked[i]) begin
                if (hits == 4'd1)      sym_d[i*3 +: 3] = pick ^ {2'b00, corrupt};
                else if (hits >= 4'd2) col_d[i]        = 1'b1;
            end
        end
    end

    // Number of receivers currently flagging a collision
    always_comb begin
        ncol = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) ncol = ncol + 4'(collision[i]);
        cnt_sum = {1'b0, collision_cnt} + 17'(ncol);
    end

    // Registered delivery and saturating collision counter
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            rxsymbol      <= '0;
            collision     <= '0;
            collision_cnt <= '0;
        end else begin
            rxsymbol      <= sym_d;
            collision     <= col_d;
            collision_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_bt_air_channel.sv
// Randomized scoreboard bench for bt_air_channel (3 devices).
module tb_bt_air_channel;

    localparam int N   = 3;
    localparam int D   = 2;
    localparam int S   = 900;
    localparam int FKW = 7;
    localparam logic [15:0] POLY = 16'b1011_0100_0000_0000;

    logic                 clk_6M = 1'b0;
    logic                 rstz   = 1'b0;
    logic [N-1:0]         txen   = '0;
    logic [3*N-1:0]       txsymbol = '0;
    logic [FKW*N-1:0]     txfk   = '0;
    logic [N-1:0]         rxen   = '0;
    logic [FKW*N-1:0]     rxfk   = '0;
    logic                 regi_err_en = 1'b0;
    logic [7:0]           regi_ber_thresh = 8'd0;
    logic [15:0]          regi_lfsr_seed  = 16'h0001;
    logic [3*N-1:0]       rxsymbol;
    logic [N-1:0]         rxlocked;
    logic [N-1:0]         collision;
    logic [15:0]          collision_cnt;

    always #5 clk_6M = ~clk_6M;

    bt_air_channel #(
        .NUM_DEV    (N),
        .DELAY      (D),
        .SETTLE_CYC (S),
        .FKW        (FKW)
    ) dut (
        .clk_6M          (clk_6M),
        .rstz            (rstz),
        .txen            (txen),
        .txsymbol        (txsymbol),
        .txfk            (txfk),
        .rxen            (rxen),
        .rxfk            (rxfk),
        .regi_err_en     (regi_err_en),
        .regi_ber_thresh (regi_ber_thresh),
        .regi_lfsr_seed  (regi_lfsr_seed),
        .rxsymbol        (rxsymbol),
        .rxlocked        (rxlocked),
        .collision       (collision),
        .collision_cnt   (collision_cnt)
    );

    typedef struct packed {
        logic [N-1:0]     en;
        logic [3*N-1:0]   sym;
        logic [FKW*N-1:0] fk;
    } snap_t;

    typedef struct packed {
        logic [3*N-1:0] sym;
        logic [N-1:0]   lock;
        logic [N-1:0]   col;
        logic [15:0]    cnt;
    } exp_t;

    exp_t  exp_q[$];
    snap_t hist[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit             m_active [N];
    bit             m_lock   [N];
    int             m_start  [N];
    logic [FKW-1:0] m_prevfk [N];
    int             m_now;
    logic [15:0]    m_lfsr;
    bit             m_errq;
    exp_t           e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, want);
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0;
            m_lock[i]   = 0;
            m_start[i]  = 0;
            m_prevfk[i] = '0;
        end
        m_now  = 0;
        m_lfsr = (regi_lfsr_seed == 16'h0) ? 16'hACE1 : regi_lfsr_seed;
        m_errq = 0;
        e      = '0;
    endtask

    // One clock edge of the channel as seen from the air
    task automatic model_edge();
        snap_t          cur, air;
        logic           corrupt;
        int             c, hits;
        logic [2:0]     s;
        logic [FKW-1:0] fk_i;
        exp_t           nx;
        cur.en  = txen;
        cur.sym = txsymbol;
        cur.fk  = txfk;
        air     = (hist.size() >= D) ? hist[hist.size()-D] : '0;
        corrupt = regi_err_en && (m_lfsr[7:0] < regi_ber_thresh);
        c       = int'(e.cnt) + $countones(e.col);
        nx      = '0;
        nx.cnt  = (c > 65535) ? 16'hFFFF : c[15:0];
        for (int i = 0; i < N; i++) begin
            fk_i = rxfk[i*FKW +: FKW];
            hits = 0;
            s    = '0;
            for (int j = 0; j < N; j++)
                if (j != i && air.en[j] && air.fk[j*FKW +: FKW] == fk_i) begin
                    hits++;
                    s = air.sym[j*3 +: 3];
                end
            if (m_lock[i]) begin
                if (hits == 1)     nx.sym[i*3 +: 3] = corrupt ? (s ^ 3'b001) : s;
                else if (hits > 1) nx.col[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            fk_i = rxfk[i*FKW +: FKW];
            if (!rxen[i]) begin
                m_active[i] = 0;
                m_lock[i]   = 0;
            end else if (!m_active[i]) begin
                m_active[i] = 1;
                m_start[i]  = m_now;
            end else if (m_lock[i]) begin
                if (fk_i != m_prevfk[i]) begin
                    m_lock[i]  = 0;
                    m_start[i] = m_now;
                end
            end else if (m_now - m_start[i] >= S) begin
                m_lock[i] = 1;
            end
            m_prevfk[i] = fk_i;
            nx.lock[i]  = m_lock[i];
        end
        if (regi_err_en && !m_errq)
            m_lfsr = (regi_lfsr_seed == 16'h0) ? 16'hACE1 : regi_lfsr_seed;
        else
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ POLY) : (m_lfsr >> 1);
        m_errq = regi_err_en;
        hist.push_back(cur);
        m_now++;
        e = nx;
        exp_q.push_back(nx);
    endtask

    task automatic step();
        @(posedge clk_6M);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_rand(input int n);
        logic [31:0] r;
        repeat (n) begin
            r = $urandom();
            txsymbol = r[3*N-1:0];
            step();
        end
    endtask

    task automatic set_tx(input int d, input logic en, input logic [FKW-1:0] fk, input logic [2:0] sym);
        txen[d]             = en;
        txfk[d*FKW +: FKW]  = fk;
        txsymbol[d*3 +: 3]  = sym;
    endtask

    task automatic set_rx(input int d, input logic en, input logic [FKW-1:0] fk);
        rxen[d]            = en;
        rxfk[d*FKW +: FKW] = fk;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rxsymbol"}, 32'(rxsymbol), 32'd0);
        check({tag, "_rxlocked"}, 32'(rxlocked), 32'd0);
        check({tag, "_collision"}, 32'(collision), 32'd0);
        check({tag, "_cnt"}, 32'(collision_cnt), 32'd0);
    endtask

    // Monitor: compares DUT outputs against the queued model response each cycle
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_6M);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("rxsymbol",      32'(rxsymbol),      32'(x.sym));
                check("rxlocked",      32'(rxlocked),      32'(x.lock));
                check("collision",     32'(collision),     32'(x.col));
                check("collision_cnt", 32'(collision_cnt), 32'(x.cnt));
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [FKW-1:0] fsel;

        model_reset();
        repeat (3) @(posedge clk_6M);
        #3;
        check_zero_outputs("reset");
        model_reset();
        rstz = 1'b1;

        // Basic delivery dev0 -> dev1 on fk 23
        set_rx(1, 1'b1, 7'd23);
        set_tx(0, 1'b1, 7'd23, 3'd0);
        run_rand(905);
        set_tx(0, 1'b1, 7'd23, 3'd1); step();
        set_tx(0, 1'b1, 7'd23, 3'd2); step();
        set_tx(0, 1'b1, 7'd23, 3'd3); step();
        run_rand(10);

        // Frequency mismatch, then retune back
        set_rx(1, 1'b1, 7'd40);
        run_rand(950);
        set_rx(1, 1'b1, 7'd23);
        run_rand(950);

        // Two transmitters on fk 5, dev2 listening
        set_rx(1, 1'b0, 7'd0);
        set_rx(2, 1'b1, 7'd5);
        set_tx(0, 1'b1, 7'd5, 3'd0);
        set_tx(1, 1'b1, 7'd5, 3'd0);
        run_rand(1000);

        // Self exclusion: dev0 transmits and listens on fk 5 alone
        set_tx(1, 1'b0, 7'd5, 3'd0);
        set_rx(2, 1'b0, 7'd0);
        set_rx(0, 1'b1, 7'd5);
        run_rand(960);

        // Error injection, heavy then none
        set_rx(0, 1'b0, 7'd0);
        set_rx(1, 1'b1, 7'd23);
        set_tx(0, 1'b1, 7'd23, 3'b110);
        regi_lfsr_seed  = 16'h0001;
        regi_ber_thresh = 8'd255;
        regi_err_en     = 1'b1;
        run(1450);
        regi_ber_thresh = 8'd0;
        run(10000);

        // Randomized traffic
        regi_err_en = 1'b0;
        regi_lfsr_seed = 16'h0000;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom();
            txen = r[N-1:0];
            for (int d = 0; d < N; d++) begin
                fsel = r[8+d] ? 7'd5 : 7'd23;
                txfk[d*FKW +: FKW] = fsel;
                if ($urandom_range(399) == 0)
                    set_rx(d, ($urandom_range(3) != 0), ($urandom_range(1) != 0) ? 7'd5 : 7'd23);
            end
            if (k % 64 == 0) begin
                regi_ber_thresh = 8'($urandom_range(255));
                regi_err_en = ($urandom_range(1) != 0);
            end
            r = $urandom();
            txsymbol = r[3*N-1:0];
            step();
        end

        // Reset during active delivery
        regi_err_en = 1'b0;
        set_tx(0, 1'b1, 7'd23, 3'd0);
        set_tx(1, 1'b0, 7'd5, 3'd0);
        set_rx(0, 1'b0, 7'd0);
        set_rx(1, 1'b1, 7'd23);
        set_rx(2, 1'b1, 7'd5);
        set_tx(2, 1'b1, 7'd5, 3'd0);
        run_rand(950);
        #2;
        rstz = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk_6M);
        #3;
        model_reset();
        rstz = 1'b1;
        run_rand(950);

        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
